shreg_delay_line: RTL and testbench

- Parametrised successor to the fixed single-bit 3-flop chain: WIDTH-bit data, DEPTH stages, per-stage valid bit, shift enable, flush, and a runtime-selectable output tap.
- Used for delay matching and pipeline alignment between datapath blocks, and as the storage core for small memories.
- Single clock domain.

---
 rtl/shreg_pkg.sv | 24 ++
 rtl/shreg_stage.sv | 35 +++
 rtl/shreg_delay_line.sv | 102 ++++++++++
 tb/tb_shreg_delay_line.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared constants and shift-operation decode for the shreg delay line.
// Optional flat tap outputs are enabled by defining SHREG_TAPS_EN.
package shreg_pkg;

  localparam int unsigned SHREG_DEFAULT_WIDTH = 8;
  localparam int unsigned SHREG_DEFAULT_DEPTH = 3;

  typedef enum logic [1:0] {
    OpHold,
    OpShift,
    OpFlush,
    OpReset
  } shreg_op_e;

  // Reset beats flush, flush beats shift.
  function automatic shreg_op_e shreg_decode_op(input logic rst, input logic flush,
                                                input logic en);
    if (rst) return OpReset;
    if (flush) return OpFlush;
    if (en) return OpShift;
    return OpHold;
  endfunction

endpackage

// File: rtl/shreg_stage.sv
// One delay-line stage: a {valid, data} register with sync reset, valid clear and enable.
// The valid bit is the MSB of the record.
module shreg_stage #(
  parameter int unsigned W = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_valid_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_d, stage_q;

  always_comb begin
    stage_d = stage_q;
    if (clr_valid_i) begin
      stage_d[W-1] = 1'b0;
    end else if (en_i) begin
      stage_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/shreg_delay_line.sv
// Parametrised shift-register delay line with per-stage valid, flush, tap mux and fill count.
// Define SHREG_TAPS_EN to expose every stage on the flat taps/taps_valid outputs.
module shreg_delay_line
  import shreg_pkg::*;
#(
  parameter int unsigned WIDTH = SHREG_DEFAULT_WIDTH,
  parameter int unsigned DEPTH = SHREG_DEFAULT_DEPTH,
  parameter int unsigned SELW  = $clog2(DEPTH),
  parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic [SELW-1:0]        sel,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  output logic [WIDTH-1:0]       last,
  output logic                   last_valid,
`ifdef SHREG_TAPS_EN
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [DEPTH-1:0]       taps_valid,
`endif
  output logic [CNTW-1:0]        fill_cnt
);

  localparam int unsigned StageW = WIDTH + 1;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  shreg_op_e op;
  stage_t    stage_q  [DEPTH];
  stage_t    stage_in [DEPTH];
  stage_t    tap;

  logic [CNTW-1:0] fill_d, fill_q;

  assign op = shreg_decode_op(rst, flush, en);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_in[i] = '{valid: din_valid, data: din};
    end else begin : g_body
      assign stage_in[i] = stage_q[i-1];
    end

    shreg_stage #(
      .W (StageW)
    ) u_stage (
      .clk_i       (clk),
      .rst_i       (rst),
      .clr_valid_i (op == OpFlush),
      .en_i        (op == OpShift),
      .d_i         (stage_in[i]),
      .q_o         (stage_q[i])
    );

`ifdef SHREG_TAPS_EN
    assign taps[i*WIDTH +: WIDTH] = stage_q[i].data;
    assign taps_valid[i]          = stage_q[i].valid;
`endif
  end

  // Out-of-range selects fall through to the all-zero default.
  always_comb begin
    tap = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel == SELW'(i)) tap = stage_q[i];
    end
  end

  assign dout       = tap.data;
  assign dout_valid = tap.valid;
  assign last       = stage_q[DEPTH-1].data;
  assign last_valid = stage_q[DEPTH-1].valid;

  // Cannot overflow: a full line always has its last stage valid, which leaves on a shift.
  always_comb begin
    fill_d = fill_q;
    unique case (op)
      OpReset, OpFlush: fill_d = '0;
      OpShift: fill_d = fill_q + CNTW'(din_valid) - CNTW'(stage_q[DEPTH-1].valid);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign fill_cnt = fill_q;

endmodule

// File: tb/tb_shreg_delay_line.sv
// Bench for shreg_delay_line: a DEPTH=3 and a DEPTH=5 instance share stimulus and are
// compared against an array model of the stage history.
module tb_shreg_delay_line;

  logic       clk = 1'b0;
  logic       rst, en, flush, din_valid;
  logic [7:0] din;
  logic [1:0] sel_a;
  logic [2:0] sel_b;
  logic [7:0] dout_a, last_a, dout_b, last_b;
  logic       dv_a, lv_a, dv_b, lv_b;
  logic [1:0] fill_a;
  logic [2:0] fill_b;
`ifdef SHREG_TAPS_EN
  logic [23:0] taps_a;
  logic [2:0]  tv_a;
  logic [39:0] taps_b;
  logic [4:0]  tv_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_d [2][5];
  logic [4:0] m_v [2];

  always #5 clk = ~clk;

  shreg_delay_line #(.WIDTH(8), .DEPTH(3)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .din        (din),
    .din_valid  (din_valid),
    .sel        (sel_a),
    .dout       (dout_a),
    .dout_valid (dv_a),
    .last       (last_a),
    .last_valid (lv_a),
`ifdef SHREG_TAPS_EN
    .taps       (taps_a),
    .taps_valid (tv_a),
`endif
    .fill_cnt   (fill_a)
  );

  shreg_delay_line #(.WIDTH(8), .DEPTH(5)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .din        (din),
    .din_valid  (din_valid),
    .sel        (sel_b),
    .dout       (dout_b),
    .dout_valid (dv_b),
    .last       (last_b),
    .last_valid (lv_b),
`ifdef SHREG_TAPS_EN
    .taps       (taps_b),
    .taps_valid (tv_b),
`endif
    .fill_cnt   (fill_b)
  );

  function automatic int dep(input int k);
    return (k == 0) ? 3 : 5;
  endfunction

  // Stage i holds the i-th most recent enabled capture.
  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_v[k] = '0;
        for (int i = 0; i < 5; i++) m_d[k][i] = '0;
      end else if (flush) begin
        m_v[k] = '0;
      end else if (en) begin
        for (int i = dep(k) - 1; i > 0; i--) begin
          m_d[k][i] = m_d[k][i-1];
          m_v[k][i] = m_v[k][i-1];
        end
        m_d[k][0] = din;
        m_v[k][0] = din_valid;
      end
    end
  endfunction

  function automatic logic [8:0] mtap(input int k, input int s);
    if (s < dep(k)) return {m_v[k][s], m_d[k][s]};
    return 9'h0;
  endfunction

  function automatic int mfill(input int k);
    int c = 0;
    for (int i = 0; i < dep(k); i++) c += int'(m_v[k][i]);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; flush = 1'b0; din = 8'hFF; din_valid = 1'b1;
    sel_a = 2'd0; sel_b = 3'd0;
    repeat (2) begin
      tick();
      n_checks++;
      if ({dv_a, dout_a} !== 9'h0) begin
        n_fail++; $display("FAIL reset_dout_a: got %h expected 000", {dv_a, dout_a});
      end
      n_checks++;
      if ({lv_a, last_a} !== 9'h0) begin
        n_fail++; $display("FAIL reset_last_a: got %h expected 000", {lv_a, last_a});
      end
      n_checks++;
      if (fill_a !== 2'd0 || fill_b !== 3'd0) begin
        n_fail++; $display("FAIL reset_fill: got %0d/%0d expected 0/0", fill_a, fill_b);
      end
      n_checks++;
      if ({lv_b, last_b, dv_b, dout_b} !== 18'h0) begin
        n_fail++; $display("FAIL reset_b: got %h expected 0", {lv_b, last_b, dv_b, dout_b});
      end
    end
  endtask

  task automatic test_fixed_delay();
    int exp_fill [4] = '{1, 2, 3, 3};
    logic [8:0] e;
    rst = 1'b0; en = 1'b1; sel_a = 2'd2;
    for (int c = 0; c < 4; c++) begin
      din = 8'(c + 1); din_valid = 1'b1;
      tick();
      n_checks++;
      if (int'(fill_a) != exp_fill[c] || int'(fill_a) != mfill(0)) begin
        n_fail++; $display("FAIL fixed_fill[%0d]: got %0d expected %0d", c, fill_a, exp_fill[c]);
      end
      e = mtap(0, 2);
      n_checks++;
      if ({lv_a, last_a} !== e) begin
        n_fail++; $display("FAIL fixed_last[%0d]: got %h expected %h", c, {lv_a, last_a}, e);
      end
      if (c == 2) begin
        n_checks++;
        if ({lv_a, last_a} !== 9'h101) begin
          n_fail++; $display("FAIL fixed_first_out: got %h expected 101", {lv_a, last_a});
        end
      end
    end
  endtask

  task automatic test_tap_select();
    logic [8:0] e;
    en = 1'b1; sel_a = 2'd1;
    for (int i = 0; i < 8; i++) begin
      din = 8'hA0 + 8'(i); din_valid = 1'b1;
      tick();
      if (i == 4) begin
        sel_a = 2'd0;
        #1;
        n_checks++;
        if ({dv_a, dout_a} !== {1'b1, 8'hA4}) begin
          n_fail++; $display("FAIL tap_switch: got %h expected 1a4", {dv_a, dout_a});
        end
      end else if (i >= 1 && sel_a == 2'd1) begin
        n_checks++;
        if (dout_a !== 8'hA0 + 8'(i - 1)) begin
          n_fail++; $display("FAIL tap_lag[%0d]: got %h expected %h", i, dout_a, 8'hA0 + 8'(i - 1));
        end
      end
      e = mtap(0, int'(sel_a));
      n_checks++;
      if ({dv_a, dout_a} !== e) begin
        n_fail++; $display("FAIL tap_model[%0d]: got %h expected %h", i, {dv_a, dout_a}, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [8:0] el, e;
    int ef;
    sel_a = 2'd1; en = 1'b1;
    repeat (3) begin
      din = 8'($urandom); din_valid = 1'($urandom);
      tick();
    end
    el = mtap(0, 2);
    ef = mfill(0);
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      din = 8'($urandom); din_valid = 1'b1;
      tick();
      n_checks++;
      if ({lv_a, last_a} !== el || int'(fill_a) != ef) begin
        n_fail++;
        $display("FAIL stall_frozen[%0d]: got %h/%0d expected %h/%0d", c, {lv_a, last_a}, fill_a,
                 el, ef);
      end
    end
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      din = 8'($urandom); din_valid = 1'($urandom);
      tick();
      e = mtap(0, 2);
      n_checks++;
      if ({lv_a, last_a} !== e || int'(fill_a) != mfill(0)) begin
        n_fail++;
        $display("FAIL stall_resume[%0d]: got %h/%0d expected %h/%0d", c, {lv_a, last_a}, fill_a,
                 e, mfill(0));
      end
    end
  endtask

  task automatic test_flush();
    logic [8:0] e;
    en = 1'b1; flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      din = 8'h10 + 8'(c); din_valid = 1'b1;
      tick();
    end
    flush = 1'b1; din = 8'h55; din_valid = 1'b1;
    tick();
    flush = 1'b0; en = 1'b0;
    n_checks++;
    if (fill_a !== 2'd0 || fill_b !== 3'd0) begin
      n_fail++; $display("FAIL flush_fill: got %0d/%0d expected 0/0", fill_a, fill_b);
    end
    for (int s = 0; s < 3; s++) begin
      sel_a = 2'(s);
      #1;
      e = mtap(0, s);
      n_checks++;
      if ({dv_a, dout_a} !== e || dout_a === 8'h55) begin
        n_fail++; $display("FAIL flush_stage[%0d]: got %h expected %h", s, {dv_a, dout_a}, e);
      end
    end
    n_checks++;
    if ({lv_a, last_a} !== 9'h010) begin
      n_fail++; $display("FAIL flush_hold: got %h expected 010", {lv_a, last_a});
    end
    flush = 1'b1; rst = 1'b1; en = 1'b1;
    tick();
    flush = 1'b0; rst = 1'b0;
    n_checks++;
    if ({lv_a, last_a, lv_b, last_b} !== 18'h0 || fill_a !== 2'd0 || fill_b !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_rst: got %h %h fill %0d/%0d expected zeros", {lv_a, last_a},
               {lv_b, last_b}, fill_a, fill_b);
    end
  endtask

  task automatic test_bubbles();
    int ef;
`ifdef SHREG_TAPS_EN
    logic [39:0] et;
`endif
    en = 1'b1; flush = 1'b0; rst = 1'b0; sel_b = 3'd7;
    for (int c = 0; c < 12; c++) begin
      din = 8'($urandom); din_valid = (c % 2 == 0);
      tick();
      n_checks++;
      if ({dv_b, dout_b} !== 9'h0) begin
        n_fail++; $display("FAIL bubble_sel7[%0d]: got %h expected 000", c, {dv_b, dout_b});
      end
      ef = (c < 4) ? mfill(1) : ((c % 2 == 0) ? 3 : 2);
      n_checks++;
      if (int'(fill_b) != ef || int'(fill_b) != mfill(1)) begin
        n_fail++; $display("FAIL bubble_fill[%0d]: got %0d expected %0d", c, fill_b, ef);
      end
`ifdef SHREG_TAPS_EN
      for (int i = 0; i < 5; i++) et[i*8 +: 8] = m_d[1][i];
      n_checks++;
      if (tv_b !== m_v[1] || taps_b !== et) begin
        n_fail++; $display("FAIL bubble_taps[%0d]: got %h/%h expected %h/%h", c, tv_b, taps_b,
                           m_v[1], et);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [8:0] e;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 19) == 0);
      en = ($urandom_range(0, 3) != 0);
      din = 8'($urandom); din_valid = 1'($urandom);
      sel_a = 2'($urandom); sel_b = 3'($urandom);
      tick();
      e = mtap(0, int'(sel_a));
      n_checks++;
      if ({dv_a, dout_a} !== e) begin
        n_fail++; $display("FAIL rnd_dout_a[%0d]: got %h expected %h", c, {dv_a, dout_a}, e);
      end
      e = mtap(1, int'(sel_b));
      n_checks++;
      if ({dv_b, dout_b} !== e) begin
        n_fail++; $display("FAIL rnd_dout_b[%0d]: got %h expected %h", c, {dv_b, dout_b}, e);
      end
      n_checks++;
      if ({lv_a, last_a} !== mtap(0, 2) || {lv_b, last_b} !== mtap(1, 4)) begin
        n_fail++; $display("FAIL rnd_last[%0d]: got %h/%h expected %h/%h", c, {lv_a, last_a},
                           {lv_b, last_b}, mtap(0, 2), mtap(1, 4));
      end
      n_checks++;
      if (int'(fill_a) != mfill(0) || int'(fill_b) != mfill(1)) begin
        n_fail++; $display("FAIL rnd_fill[%0d]: got %0d/%0d expected %0d/%0d", c, fill_a, fill_b,
                           mfill(0), mfill(1));
      end
      sel_b = 3'($urandom);
      #1;
      e = mtap(1, int'(sel_b));
      n_checks++;
      if ({dv_b, dout_b} !== e) begin
        n_fail++; $display("FAIL rnd_sel_follow[%0d]: got %h expected %h", c, {dv_b, dout_b}, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; din = '0; din_valid = 1'b0;
    sel_a = '0; sel_b = '0;
    for (int k = 0; k < 2; k++) begin
      m_v[k] = '0;
      for (int i = 0; i < 5; i++) m_d[k][i] = '0;
    end
    test_reset();
    test_fixed_delay();
    test_tap_select();
    test_stall();
    test_flush();
    test_bubbles();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
